// File: rtl/instr_encoder_loader_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader_if
// Purpose : bundles the two handshakes of the instruction encoder/loader.
//           The field side is valid/ready: the producer offers one
//           instruction's fields and the encoder accepts them. The memory
//           side is a write port with a ready handshake into instruction
//           memory.
// Signals :
//   in_valid / in_ready   field handshake
//   in_kind               0 R,1 ADDI,2 ORI,3 ANDI,4 BEQ,5 BNE,6 LUI,7 LW,
//                         8 SW,9 J; 10-15 are illegal
//   in_rs/rt/rd/shamt     register and shift fields
//   in_funct              R-type function code
//   in_imm                I-type immediate
//   in_target             J-type jump target
//   mem_we / mem_ready    memory write request and its acceptance
//   mem_addr              word address of the current write
//   mem_wdata             encoded 32-bit instruction word
// Modports: master = field producer and memory model (the bench side),
//           slave  = the encoder/loader itself.
// ---------------------------------------------------------------------------
interface instr_encoder_loader_if #(
    parameter int ADDR_WIDTH = 6
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            in_kind;
    logic [4:0]            in_rs;
    logic [4:0]            in_rt;
    logic [4:0]            in_rd;
    logic [4:0]            in_shamt;
    logic [5:0]            in_funct;
    logic [15:0]           in_imm;
    logic [25:0]           in_target;
    logic                  mem_we;
    logic                  mem_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
// Purpose : writer-side counterpart of the MIPS opcode decoder. Accepts
//           instruction fields, encodes them into 32-bit MIPS words and
//           writes the words sequentially into instruction memory. Used on
//           the boot path to load programs.
// Parameters:
//   ADDR_WIDTH  word-address width of mem_addr
//   DEPTH       words loadable before the session is full
//               (1 <= DEPTH <= 2**ADDR_WIDTH)
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   i_start   begin/restart a load session (beats every other input)
//   bus       field handshake and memory write port (slave side)
//   o_count   words written this session
//   o_full    session has written DEPTH words
//   o_error   sticky flag: an illegal in_kind was offered this session
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_start,
    instr_encoder_loader_if.slave bus,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_error
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        FULL
    } state_t;

    state_t                r_state;
    logic                  r_inReady;
    logic                  r_memWe;
    logic                  r_full;
    logic                  r_error;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [ADDR_WIDTH:0]   r_count;

    logic [31:0]           w_word;
    logic                  w_legal;
    logic [ADDR_WIDTH:0]   w_countNext;

    assign w_countNext = r_count + 1'b1;

    // Field-to-word encoder. LUI has no rs operand, so that field is
    // forced to zero regardless of what the producer supplied.
    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        case (bus.in_kind)
            4'd0: w_word = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct};
            4'd1: w_word = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd2: w_word = {6'h0D, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd3: w_word = {6'h0C, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd4: w_word = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd5: w_word = {6'h05, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd6: w_word = {6'h0F, 5'd0,      bus.in_rt, bus.in_imm};
            4'd7: w_word = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd8: w_word = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm};
            4'd9: w_word = {6'h02, bus.in_target};
            default: w_legal = 1'b0;
        endcase
    end

    // Session controller. Every output is a register so the memory sees a
    // glitch-free write port. i_start wins over everything else and drops
    // any word still waiting in WRITE. When the last word lands the
    // address goes back to zero rather than past DEPTH-1, so it never
    // points outside the loadable region.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_inReady <= 1'b0;
            r_memWe   <= 1'b0;
            r_full    <= 1'b0;
            r_error   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_count   <= '0;
        end else if (i_start) begin
            r_state   <= ACCEPT;
            r_inReady <= 1'b1;
            r_memWe   <= 1'b0;
            r_full    <= 1'b0;
            r_error   <= 1'b0;
            r_addr    <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_inReady <= 1'b0;
                end
                ACCEPT: begin
                    if (bus.in_valid && r_inReady) begin
                        if (w_legal) begin
                            r_wdata   <= w_word;
                            r_memWe   <= 1'b1;
                            r_inReady <= 1'b0;
                            r_state   <= WRITE;
                        end else begin
                            r_error   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        r_memWe <= 1'b0;
                        r_count <= w_countNext;
                        if (w_countNext == FULL_COUNT) begin
                            r_full    <= 1'b1;
                            r_inReady <= 1'b0;
                            r_addr    <= '0;
                            r_state   <= FULL;
                        end else begin
                            r_inReady <= 1'b1;
                            r_addr    <= r_addr + 1'b1;
                            r_state   <= ACCEPT;
                        end
                    end
                end
                FULL: begin
                    r_inReady <= 1'b0;
                    r_full    <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_inReady;
    assign bus.mem_we    = r_memWe;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign o_count       = r_count;
    assign o_full        = r_full;
    assign o_error       = r_error;

endmodule
